// File: rtl/move_request_gen.sv
// Move-entry front end for the chess clock: synchronises and debounces the
// move button, emits a fixed-length `moved` window and keeps per-player counts.
module move_request_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 4,
    parameter int GAP_CYCLES      = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       player_turn,
    input  logic       end_game,
    output logic       moved,
    output logic       rejected,
    output logic       busy,
    output logic [7:0] move_count_p0,
    output logic [7:0] move_count_p1,
    output logic [2:0] fsm_state
);

    localparam int MAX_A   = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] DEBOUNCE = 3'd1;
    localparam logic [2:0] ASSERT   = 3'd2;
    localparam logic [2:0] RELEASE  = 3'd3;
    localparam logic [2:0] GAP      = 3'd4;

    logic             sync1, btn_s;
    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             rejected_n, inc_p0, inc_p1;

    assign fsm_state = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            btn_s <= sync1;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rejected_n = 1'b0;
        inc_p0     = 1'b0;
        inc_p1     = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_n = DEBOUNCE;
                    cnt_n   = '0;
                end
            end
            DEBOUNCE: begin
                if (!btn_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    cnt_n = '0;
                    if (end_game) begin
                        state_n    = RELEASE;
                        rejected_n = 1'b1;
                    end else begin
                        // Player is sampled at the decision edge, not when moved is seen.
                        state_n = ASSERT;
                        inc_p0  = ~player_turn;
                        inc_p1  = player_turn;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            ASSERT: begin
                if (cnt == HOLD_LAST) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            RELEASE: begin
                // Any high sample restarts the release qualification, so a held button never re-fires.
                if (btn_s) begin
                    cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = GAP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            moved         <= 1'b0;
            rejected      <= 1'b0;
            busy          <= 1'b0;
            move_count_p0 <= 8'd0;
            move_count_p1 <= 8'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            moved    <= (state_n == ASSERT);
            rejected <= rejected_n;
            busy     <= (state_n != IDLE);
            if (inc_p0 && move_count_p0 != 8'hFF) move_count_p0 <= move_count_p0 + 8'd1;
            if (inc_p1 && move_count_p1 != 8'hFF) move_count_p1 <= move_count_p1 + 8'd1;
        end
    end

endmodule

// File: tb/tb_move_request_gen.sv
// Bench for move_request_gen with DEBOUNCE=4, HOLD=3, GAP=2: a per-edge vector
// table for press/reject timing plus directed multi-press and reset sequences.
module tb_move_request_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic       player_turn;
    logic       end_game;
    logic       moved;
    logic       rejected;
    logic       busy;
    logic [7:0] move_count_p0;
    logic [7:0] move_count_p1;
    logic [2:0] fsm_state;

    move_request_gen #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(3), .GAP_CYCLES(2)) dut (
        .clock(clock), .reset(reset), .btn_raw(btn_raw), .player_turn(player_turn),
        .end_game(end_game), .moved(moved), .rejected(rejected), .busy(busy),
        .move_count_p0(move_count_p0), .move_count_p1(move_count_p1), .fsm_state(fsm_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit       rst;
        bit       btn;
        bit       pl;
        bit       eg;
        bit       e_moved;
        bit       e_rej;
        bit       e_busy;
        logic [7:0] e_c0;
        logic [7:0] e_c1;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int   hi_acc, lo_run, min_lo;
    bit   prev_moved, had_hi;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        btn_raw     = 1'b0;
        player_turn = 1'b0;
        end_game    = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_moved", moved, 0);
        check("rst_rejected", rejected, 0);
        check("rst_busy", busy, 0);
        check("rst_c0", move_count_p0, 0);
        check("rst_c1", move_count_p1, 0);
        check("rst_state", fsm_state, 0);
        reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (moved) begin
            if (!prev_moved && had_hi && lo_run < min_lo) min_lo = lo_run;
            hi_acc++;
            lo_run = 0;
            had_hi = 1'b1;
        end else begin
            lo_run++;
        end
        prev_moved = moved;
        @(negedge clock);
    endtask

    task automatic press(input bit pl, output int hi, output bit timed_out);
        player_turn = pl;
        btn_raw     = 1'b1;
        hi_acc      = 0;
        timed_out   = 1'b1;
        repeat (10) step();
        btn_raw = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        hi = hi_acc;
    endtask

    task automatic add(input bit rst, input bit btn, input bit eg, input bit m, input bit rj,
                       input bit b, input logic [7:0] c0);
        vec_t v;
        v.rst = rst; v.btn = btn; v.pl = 1'b0; v.eg = eg;
        v.e_moved = m; v.e_rej = rj; v.e_busy = b; v.e_c0 = c0; v.e_c1 = 8'd0;
        tbl.push_back(v);
    endtask

    initial begin
        int  hi, good, tos, first_edge;
        bit  to;

        // Clean press held 20 edges, released before edge 21: moved on 7-9, idle at 28.
        for (int k = 1; k <= 28; k++)
            add(k == 1, k <= 20, 1'b0, (k >= 7 && k <= 9), 1'b0, (k >= 3 && k <= 27),
                (k >= 7) ? 8'd1 : 8'd0);
        // Press with end_game high: rejected only on edge 7, idle again at 18.
        for (int k = 1; k <= 18; k++)
            add(k == 1, k <= 10, 1'b1, 1'b0, (k == 7), (k >= 3 && k <= 17), 8'd0);

        prev_moved = 1'b0; had_hi = 1'b0; lo_run = 0; min_lo = 1000; hi_acc = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            btn_raw     = tbl[i].btn;
            player_turn = tbl[i].pl;
            end_game    = tbl[i].eg;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d_moved", i), moved, tbl[i].e_moved);
            check($sformatf("vec%0d_rejected", i), rejected, tbl[i].e_rej);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("vec%0d_c0", i), move_count_p0, tbl[i].e_c0);
            check($sformatf("vec%0d_c1", i), move_count_p1, tbl[i].e_c1);
            @(negedge clock);
        end

        // Bounce: two-cycle toggles never survive the debounce window.
        do_reset();
        hi_acc = 0;
        for (int i = 0; i < 12; i++) begin
            btn_raw = ((i / 2) % 2 == 0);
            step();
        end
        btn_raw = 1'b0;
        repeat (10) step();
        check("bounce_moved_cycles", hi_acc, 0);
        check("bounce_c0", move_count_p0, 0);
        check("bounce_c1", move_count_p1, 0);
        check("bounce_busy", busy, 0);

        // Alternating players 0,1,0,1,0.
        do_reset();
        had_hi = 1'b0; min_lo = 1000; prev_moved = 1'b0;
        tos = 0;
        for (int p = 0; p < 5; p++) begin
            press(p[0], hi, to);
            if (to) tos++;
            check($sformatf("alt%0d_hold", p), hi, 3);
        end
        check("alt_timeouts", tos, 0);
        check("alt_c0", move_count_p0, 3);
        check("alt_c1", move_count_p1, 2);
        check("alt_min_gap_ok", (min_lo >= 2), 1);

        // end_game rising on the second ASSERT cycle does not shorten moved.
        do_reset();
        hi_acc = 0;
        btn_raw = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (moved) break;
        end
        end_game = 1'b1;
        repeat (8) step();
        btn_raw = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!busy) begin
                to = 1'b0;
                break;
            end
        end
        check("eg_late_timeout", to, 0);
        check("eg_late_hold", hi_acc, 3);
        check("eg_late_c0", move_count_p0, 1);
        check("eg_late_rejected", rejected, 0);
        end_game = 1'b0;

        // Saturation: 260 presses by player 1.
        do_reset();
        good = 0; tos = 0;
        for (int p = 0; p < 260; p++) begin
            press(1'b1, hi, to);
            if (hi == 3) good++;
            if (to) tos++;
        end
        check("sat_pulses", good, 260);
        check("sat_timeouts", tos, 0);
        check("sat_c1", move_count_p1, 255);
        check("sat_c0", move_count_p0, 0);

        // Asynchronous reset mid-ASSERT, then re-press timing from release.
        do_reset();
        btn_raw = 1'b1;
        player_turn = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (moved) begin
                to = 1'b0;
                break;
            end
        end
        check("ar_reach_assert", to, 0);
        check("ar_c0_before", move_count_p0, 1);
        #1;
        reset = 1'b1;
        #1;
        check("ar_moved", moved, 0);
        check("ar_busy", busy, 0);
        check("ar_c0", move_count_p0, 0);
        check("ar_c1", move_count_p1, 0);
        @(negedge clock);
        reset = 1'b0;
        first_edge = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clock);
            #1;
            if (moved && first_edge == 0) first_edge = e;
        end
        check("ar_repress_edge", first_edge, 7);
        check("ar_repress_c0", move_count_p0, 1);
        btn_raw = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/move_request_gen.md
# move_request_gen

Front-end move-entry controller for the chess-clock game. It turns a raw, bouncy "move done" push-button into the clean `moved` level that the turn timer consumes. The timer toggles `player_turn` on the second cycle of a `moved` high level and re-arms only after `moved` returns low. This block debounces the button, suppresses moves once `end_game` is set, holds `moved` for a fixed window, enforces release and gap, and keeps per-player move counts for the display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles `btn_s` must be stable for a press or release to count (10 ms at 100 MHz); must be ≥ 1.
- `HOLD_CYCLES`, default 4: cycles `moved` stays high per accepted move; must be ≥ 2, because the timer acts on the 2nd cycle.
- `GAP_CYCLES`, default 4: minimum cycles `moved` stays low before the next move can start; must be ≥ 1.

Ports:
- `clock` input 1: system clock, 100 MHz. One clock; reset is asynchronous and active-high.
- `reset` input 1: asynchronous, active-high; returns all state to reset values immediately.
- `btn_raw` input 1: asynchronous push-button, active-high.
- `player_turn` input 1: current player from the turn timer (0 = player 0).
- `end_game` input 1: from the turn timer; when high, new moves are rejected.
- `moved` output 1: move request level to the turn timer.
- `rejected` output 1: one-cycle pulse when a debounced press arrives while `end_game` = 1.
- `busy` output 1: high whenever the state is not IDLE.
- `move_count_p0` output 8: accepted moves by player 0, saturating.
- `move_count_p1` output 8: accepted moves by player 1, saturating.

## Operation
- **Synchronizer:** `btn_raw` passes through a 2-flop synchronizer to give `btn_s`. Only `btn_s` is used.
- **FSM states:** IDLE, DEBOUNCE, ASSERT, RELEASE, GAP.
- **IDLE:**
  - `btn_s` = 1 → DEBOUNCE, `cnt` = 0.
- **DEBOUNCE:**
  - `btn_s` = 0 → IDLE (glitch discarded).
  - Otherwise, if `cnt` == DEBOUNCE_CYCLES−1:
    - `end_game` = 1 → RELEASE, with `rejected` pulsed for that cycle.
    - `end_game` = 0 → ASSERT, `cnt` = 0. On this transition, sample `player_turn` and increment that player's counter, holding it at 255 if already 255.
  - Otherwise `cnt`++.
- **ASSERT:**
  - `moved` = 1 for exactly HOLD_CYCLES cycles, then → RELEASE, `cnt` = 0.
  - `btn_s` and `end_game` are ignored here; once started, the hold always completes.
- **RELEASE:**
  - `moved` = 0.
  - `btn_s` = 1 resets `cnt` to 0.
  - `btn_s` = 0 for DEBOUNCE_CYCLES consecutive cycles → GAP, `cnt` = 0.
  - Holding the button therefore never produces a second move.
- **GAP:** `moved` = 0 for GAP_CYCLES cycles → IDLE. A press during GAP is ignored until IDLE samples it.
- **Registered outputs:** `moved` is registered and glitch-free. `busy` = (state ≠ IDLE), also registered.
- **Counter width:** `cnt` is wide enough for max(DEBOUNCE_CYCLES, HOLD_CYCLES, GAP_CYCLES).

## Timing
- **Reset values:** on `reset`, `moved` = 0, `rejected` = 0, `busy` = 0, both counts = 0, state = IDLE, `cnt` = 0, synchronizer flops = 0. These take effect asynchronously.
- **Reset mid-ASSERT:** `moved` drops without waiting for a clock edge.
- **Press latency:** with `btn_raw` stable high from before edge 1, `moved` rises at edge DEBOUNCE_CYCLES+3.
- **Hold length:** `moved` stays high for exactly HOLD_CYCLES edges.
- **Count update:** the move count changes on the same edge that `moved` rises.
- **Release to next move:** from `btn_raw` falling (stable), the earliest return to IDLE is DEBOUNCE_CYCLES+GAP_CYCLES+2 edges after ASSERT ends, or later if the button is still held.
- **Rejected pulse:** `rejected` rises at edge DEBOUNCE_CYCLES+3 and lasts 1 cycle. `moved` stays 0.
- **`end_game` timing:** `end_game` rising during DEBOUNCE applies at the decision edge. `end_game` rising during ASSERT does not shorten `moved`.

## Test plan
1. **Clean press.** Params DEBOUNCE=4, HOLD=3, GAP=2. `btn_raw` high for 20 cycles with `player_turn` = 0 → `moved` high on edges 7–9. `move_count_p0` = 1 from edge 7. `move_count_p1` = 0. No second pulse while the button is held.
2. **Bounce rejection.** `btn_raw` toggles every 2 cycles for 12 cycles, then goes low → `moved` never rises, counts stay 0, `busy` returns to 0.
3. **Alternating players.** Five presses with `player_turn` toggling 0,1,0,1,0 → `move_count_p0` = 3, `move_count_p1` = 2. Each `moved` high window is 3 cycles, with ≥ 2 low cycles between windows.
4. **End of game.** `end_game` = 1, then a clean press → `rejected` is a 1-cycle pulse at edge 7, `moved` stays 0, counts unchanged. Separately, `end_game` rising on the 2nd ASSERT cycle → `moved` still lasts 3 cycles.
5. **Saturation.** 260 presses with `player_turn` = 1 → `move_count_p1` = 255. `moved` still pulses on every press.
6. **Async reset.** Assert `reset` for a half cycle during ASSERT → `moved`, `busy` and both counts are 0 immediately. The next clean press gives `moved` at edge 7 after reset is released.
